rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares a single downstream resource (e.g. the 4-to-2 encoder datapath or any shared bus port) between four request lines. It registers a one-hot grant plus its 2-bit encoded index, holds the grant until the owner releases it, drops its request, or exceeds a hold limit, then rotates priority. It sits between the requesting blocks and the shared resource.

---
 rtl/rr_arbiter4.sv | 154 +++++++++++++++
 tb/tb_rr_arbiter4.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded index
// and an optional hold-time limit that forces release of a long-held grant.
module rr_arbiter4 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // state   | meaning
    // S_IDLE  | no grant active, waiting for any request
    // S_GRANT | one requester owns the resource, hold counter running
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] r_idx;
    logic [3:0] r_gnt;
    logic [7:0] r_cnt;
    logic       r_timeout;

    logic [1:0] w_ptr_nxt;
    logic [1:0] w_idx_nxt;
    logic [3:0] w_gnt_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_timeout_nxt;

    logic       w_owner_req;
    logic       w_hold_hit;
    logic       w_release;
    logic [1:0] w_ptr_rel;
    logic [3:0] w_req_rel;
    logic [2:0] w_pick_idle;
    logic [2:0] w_pick_rel;

    // Returns {found, index} of the first set bit at or after start, with wrap.
    function automatic logic [2:0] f_pick(input logic [3:0] reqs, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!res[2] && reqs[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_owner_req = req[r_idx];
    assign w_hold_hit  = HOLD_EN && (r_cnt == HOLD_LAST);
    assign w_release   = (r_state == S_GRANT) && (done || !w_owner_req || w_hold_hit);
    assign w_ptr_rel   = r_idx + 2'd1;
    // The releasing owner sits out the same-edge re-arbitration.
    assign w_req_rel   = req & ~(4'b0001 << r_idx);
    assign w_pick_idle = f_pick(req, r_ptr);
    assign w_pick_rel  = f_pick(w_req_rel, w_ptr_rel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_idx     <= 2'd0;
            r_gnt     <= 4'b0000;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_gnt     <= w_gnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_idle[2]) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_release && !w_pick_rel[2]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_gnt_nxt     = r_gnt;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 8'd0;
                if (w_pick_idle[2]) begin
                    w_idx_nxt = w_pick_idle[1:0];
                    w_gnt_nxt = 4'b0001 << w_pick_idle[1:0];
                end else begin
                    w_idx_nxt = 2'd0;
                    w_gnt_nxt = 4'b0000;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt     = w_ptr_rel;
                    w_cnt_nxt     = 8'd0;
                    // Only a release caused purely by the hold limit counts as a timeout.
                    w_timeout_nxt = !done && w_owner_req && w_hold_hit;
                    if (w_pick_rel[2]) begin
                        w_idx_nxt = w_pick_rel[1:0];
                        w_gnt_nxt = 4'b0001 << w_pick_rel[1:0];
                    end else begin
                        w_idx_nxt = 2'd0;
                        w_gnt_nxt = 4'b0000;
                    end
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_idx_nxt = 2'd0;
                w_gnt_nxt = 4'b0000;
                w_cnt_nxt = 8'd0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = |r_gnt;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance with a short hold limit for
// arbitration and timeout cases, one with the default limit for the 16-cycle hold.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt4;
    logic [1:0] idx4;
    logic       val4;
    logic       to4;
    logic [3:0] gnt16;
    logic [1:0] idx16;
    logic       val16;
    logic       to16;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter4 #(.HOLD_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4), .timeout(to4)
    );

    rr_arbiter4 dut16 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt16), .gnt_idx(idx16), .gnt_valid(val16), .timeout(to16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                        input logic et);
        chk({tag, "_gnt"}, 32'(gnt4), 32'(eg));
        chk({tag, "_idx"}, 32'(idx4), 32'(ei));
        chk({tag, "_valid"}, 32'(val4), 32'(|eg));
        chk({tag, "_timeout"}, 32'(to4), 32'(et));
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        tick(); tick();
        chk4("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk4("first_grant", 4'b0001, 2'd0, 1'b0);

        done = 1'b1;
        tick(); chk4("rr1", 4'b0010, 2'd1, 1'b0);
        tick(); chk4("rr2", 4'b0100, 2'd2, 1'b0);
        tick(); chk4("rr3", 4'b1000, 2'd3, 1'b0);
        tick(); chk4("rr0", 4'b0001, 2'd0, 1'b0);
        tick(); chk4("rr1b", 4'b0010, 2'd1, 1'b0);
        tick(); chk4("rr2b", 4'b0100, 2'd2, 1'b0);

        req = 4'b0101;
        tick(); chk4("wrap0", 4'b0001, 2'd0, 1'b0);
        tick(); chk4("skip2", 4'b0100, 2'd2, 1'b0);

        req = 4'b0010;
        tick(); chk4("to_owner1", 4'b0010, 2'd1, 1'b0);
        done = 1'b0; req = 4'b1000;
        tick(); chk4("reqdrop", 4'b1000, 2'd3, 1'b0);
        req = 4'b0000;
        tick(); chk4("reqdrop_idle", 4'b0000, 2'd0, 1'b0);

        req = 4'b0010;
        tick(); chk4("hold_c1", 4'b0010, 2'd1, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            tick(); chk4("hold_cn", 4'b0010, 2'd1, 1'b0);
        end
        tick(); chk4("hold_timeout", 4'b0000, 2'd0, 1'b1);
        tick(); chk4("hold_regrant", 4'b0010, 2'd1, 1'b0);

        req = 4'b1000; done = 1'b1;
        tick(); chk4("done_and_drop", 4'b1000, 2'd3, 1'b0);
        done = 1'b0; req = 4'b0000;
        tick(); chk4("to_idle", 4'b0000, 2'd0, 1'b0);
        done = 1'b1;
        tick(); chk4("done_in_idle", 4'b0000, 2'd0, 1'b0);
        done = 1'b0; req = 4'b0101;
        tick(); chk4("ptr_after_idle_done", 4'b0001, 2'd0, 1'b0);

        tick(); tick(); tick();
        chk4("hold_last_cycle", 4'b0001, 2'd0, 1'b0);
        req = 4'b0100;
        tick(); chk4("drop_at_limit", 4'b0100, 2'd2, 1'b0);

        rst = 1'b1; req = 4'b0110;
        tick(); chk4("reset_mid_grant", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick(); chk4("after_reset_ptr0", 4'b0010, 2'd1, 1'b0);

        rst = 1'b1; req = 4'b0001; done = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("h16_c1_gnt", 32'(gnt16), 32'h1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("h16_cn_gnt", 32'(gnt16), 32'h1);
            chk("h16_cn_timeout", 32'(to16), 32'h0);
        end
        tick();
        chk("h16_drop_gnt", 32'(gnt16), 32'h0);
        chk("h16_drop_valid", 32'(val16), 32'h0);
        chk("h16_timeout", 32'(to16), 32'h1);
        tick();
        chk("h16_regrant_gnt", 32'(gnt16), 32'h1);
        chk("h16_regrant_idx", 32'(idx16), 32'h0);
        chk("h16_regrant_timeout", 32'(to16), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
